// File: rtl/branch_predict_unit_pkg.sv
// Shared RISC-V branch definitions: funct3 condition encodings,
// predictor counter reset value and saturating counter helper.
package branch_predict_unit_pkg;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_RSV2 = 3'b010,
    F3_RSV3 = 3'b011,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  // weakly not-taken
  localparam logic [1:0] BHT_CNT_RST = 2'b01;

  function automatic logic [1:0] sat_cnt2(
    input logic [1:0] c,
    input logic       up
  );
    if (up) begin
      return (c == 2'b11) ? c : c + 2'b01;
    end
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/branch_predict_unit_bht_2bit.sv
// Branch history table of 2-bit saturating counters.
// Ports: rd_idx_i -> rd_taken_o (comb read); upd_* (sync update).
module bht_2bit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  logic [1:0] cnt_q [ENTRIES];
  logic [1:0] cnt_d;

  // read returns the stored value; no bypass of a
  // same-cycle update
  assign rd_taken_o = cnt_q[rd_idx_i][1];

  always_comb begin
    cnt_d = sat_cnt2(cnt_q[upd_idx_i], upd_taken_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        cnt_q[i] <= BHT_CNT_RST;
      end
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution, redirect generation and 2-bit BHT prediction.
// Ports: if_* fetch lookup; ex_* resolve inputs; redirect/perf outs.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_branch,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_pred_taken,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [XLEN-1:0]  link_addr,
  output logic             target_misaligned,
  output logic             illegal_cond,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  br_funct3_e      f3;
  logic            cond_taken;
  logic            actual_taken;
  logic            mispredict;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            bht_upd;
  logic            jump_cnt;

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  assign f3 = br_funct3_e'(ex_funct3);

  always_comb begin
    cond_taken   = 1'b0;
    illegal_cond = 1'b0;
    unique case (f3)
      F3_BEQ:  cond_taken = (ex_rs1 == ex_rs2);
      F3_BNE:  cond_taken = (ex_rs1 != ex_rs2);
      F3_BLT:  cond_taken =
        ($signed(ex_rs1) < $signed(ex_rs2));
      F3_BGE:  cond_taken =
        ($signed(ex_rs1) >= $signed(ex_rs2));
      F3_BLTU: cond_taken = (ex_rs1 < ex_rs2);
      F3_BGEU: cond_taken = (ex_rs1 >= ex_rs2);
      F3_RSV2,
      F3_RSV3: illegal_cond = ex_branch;
    endcase
  end

  assign pc_plus4  = ex_pc + XLEN'(4);
  assign link_addr = pc_plus4;
  assign jalr_sum  = ex_rs1 + ex_imm;

  // jumps win over the branch flag if both are set
  always_comb begin
    actual_taken = 1'b0;
    mispredict   = 1'b0;
    target       = ex_pc + ex_imm;
    if (ex_jalr) begin
      actual_taken = 1'b1;
      mispredict   = 1'b1;
      target       = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (ex_jal) begin
      actual_taken = 1'b1;
      mispredict   = ~ex_pred_taken;
    end else if (ex_branch) begin
      actual_taken = cond_taken;
      mispredict   = cond_taken ^ ex_pred_taken;
    end
  end

  assign target_misaligned =
    ex_valid & actual_taken & (target[1:0] != 2'b00);

  assign redirect =
    ex_valid & mispredict & ~target_misaligned;

  always_comb begin
    redirect_pc = '0;
    if (redirect) begin
      redirect_pc = actual_taken ? target : pc_plus4;
    end
  end

  assign bht_upd = ex_valid & ex_branch & ~ex_stall &
                   ~illegal_cond & ~target_misaligned;

  assign jump_cnt = ex_valid & ~ex_stall &
                    (ex_jal | ex_jalr);

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (if_pc[IDX_W+1:2]),
    .rd_taken_o  (if_pred_taken),
    .upd_en_i    (bht_upd),
    .upd_idx_i   (ex_pc[IDX_W+1:2]),
    .upd_taken_i (actual_taken)
  );

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if ((bht_upd | jump_cnt) && !(&branch_cnt_q)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (!ex_stall && redirect && !(&mispred_cnt_q)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width; BHT_ENTRIES, default 64, power of two, predictor depth; CNT_W, default 32, performance counter width.
REQ-002 Ports SHALL be, in this order (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  synchronous reset, active-high
  if_pc  in  XLEN  fetch PC for prediction lookup
  if_pred_taken  out  1  predicted direction for if_pc
  ex_valid  in  1  EX holds a valid instruction
  ex_stall  in  1  EX frozen this cycle
  ex_branch  in  1  conditional branch
  ex_jal  in  1  JAL
  ex_jalr  in  1  JALR
  ex_funct3  in  3  branch condition select
  ex_rs1, ex_rs2, ex_imm, ex_pc  in  XLEN  forwarded operands, immediate, instruction PC
  ex_pred_taken  in  1  prediction carried down the pipe with this instruction
  redirect  out  1  flush younger instructions and load redirect_pc
  redirect_pc  out  XLEN  corrected fetch address
  link_addr  out  XLEN  ex_pc+4, for the rd writeback of JAL/JALR
  target_misaligned  out  1  taken target not 4-byte aligned
  illegal_cond  out  1  ex_branch with funct3 010 or 011
  branch_cnt, mispred_cnt  out  CNT_W  performance counters

Function
REQ-003 Condition by funct3 SHALL be: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 SHALL evaluate not-taken and assert illegal_cond.
REQ-004 actual_taken SHALL be the condition result for ex_branch and 1 for ex_jal or ex_jalr.
REQ-005 target SHALL be ex_pc+ex_imm for branch and JAL, and (ex_rs1+ex_imm) with bit 0 cleared for JALR; all sums SHALL be modulo 2^XLEN.
REQ-006 target_misaligned SHALL equal ex_valid & actual_taken & (target[1:0]!=0).
REQ-007 Mispredict SHALL be: branch with actual_taken!=ex_pred_taken; JAL with !ex_pred_taken; JALR always.
REQ-008 redirect SHALL equal ex_valid & mispredict & !target_misaligned, combinationally in the same cycle.
REQ-009 redirect_pc SHALL be target when actual_taken, else ex_pc+4; it SHALL be 0 when redirect is 0.
REQ-010 BHT SHALL hold BHT_ENTRIES 2-bit saturating counters indexed by pc[log2(BHT_ENTRIES)+1:2].
REQ-011 if_pred_taken SHALL be counter[idx(if_pc)][1], read combinationally.
REQ-012 On a clock edge with ex_valid & ex_branch & !ex_stall & !illegal_cond & !target_misaligned, counter[idx(ex_pc)] SHALL increment (saturating at 3) if taken, else decrement (saturating at 0).
REQ-013 A same-cycle lookup and update of the same entry SHALL return the pre-update value; no bypass.
REQ-014 branch_cnt SHALL increment on each qualified update of REQ-012 and on each valid, unstalled JAL/JALR; mispred_cnt SHALL increment in each unstalled cycle with redirect=1; both SHALL saturate at all-ones.
REQ-015 ex_stall=1 SHALL block all state updates; combinational outputs SHALL still reflect the inputs.

Reset
REQ-016 While rst=1 at a clock edge, all counters SHALL reset to 2'b01 (weakly not-taken), and branch_cnt and mispred_cnt SHALL reset to 0.
REQ-017 rst SHALL take priority over any simultaneous update.
REQ-018 The combinational outputs SHALL depend only on inputs and state; redirect SHALL require ex_valid even during reset.

Structure
REQ-019 The funct3 encodings and the counter reset value SHALL live in the shared riscv package.
REQ-020 The predictor array SHALL be a sub-module bht_2bit, with one combinational read port and one synchronous update port.
REQ-021 Condition, target and redirect logic SHALL remain in the top module.

Verification
REQ-022 After reset, if_pc=0x40 SHALL give if_pred_taken=0, and branch_cnt and mispred_cnt SHALL be 0.
REQ-023 Apply BEQ with rs1=rs2=5, pc=0x100, imm=0x20, pred=0. The bench SHALL see redirect=1 and redirect_pc=0x120. A second identical BEQ SHALL give if_pred_taken(0x100)=1.
REQ-024 Apply BLT with rs1=0xFFFFFFFF, rs2=1, pred=1. The bench SHALL see no redirect. The same operands with BLTU and pred=1 SHALL give redirect=1 and redirect_pc=pc+4.
REQ-025 Apply JALR with rs1=0x1003, imm=0. The bench SHALL see redirect_pc=0x1002 and target_misaligned=1, with redirect=0 and no counter update.
REQ-026 Apply four taken branches to one entry, then a stalled not-taken branch. The counter SHALL stay at 3, and branch_cnt SHALL read 4.
REQ-027 Assert rst in the same cycle as a qualified update. The entry SHALL read 01 and both performance counters SHALL read 0.
